instr_register_gen2: RTL and testbench
======================================

INSTR_REGISTER_GEN2 -- requirements
Module: instr_register_gen2

Interface
REQ-001 SHALL have parameter OP_W, default 32: signed operand width, >= 4.
REQ-002 SHALL have parameter DEPTH, default 32: entry count, power of 2, >= 2.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH): pointer width, never overridden.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_en  input  1  write strobe.
REQ-007 SHALL have port opcode  input  3  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-008 SHALL have port operand_a  input  OP_W  signed operand A.
REQ-009 SHALL have port operand_b  input  OP_W  signed operand B.
REQ-010 SHALL have port write_pointer  input  AW  write entry index.
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port read_pointer  input  AW  read entry index.
REQ-013 SHALL have port rd_valid  output  1  read data valid, one-cycle pulse.
REQ-014 SHALL have port rd_opcode  output  3  stored opcode.
REQ-015 SHALL have port rd_op_a  output  OP_W  stored operand A.
REQ-016 SHALL have port rd_op_b  output  OP_W  stored operand B.
REQ-017 SHALL have port rd_result  output  2*OP_W  stored signed result.
REQ-018 SHALL have port rd_err  output  1  stored divide-by-zero flag.
REQ-019 SHALL have port rd_entry_valid  output  1  entry written since reset.
REQ-020 SHALL have port entry_count  output  AW+1  number of valid entries.

Function
REQ-021 Write: rising clk with load_en=1 SHALL store {opcode, operand_a, operand_b, result, err} in entry[write_pointer] and set its valid bit; contents readable from the next cycle.
REQ-022 Result SHALL use operands sign-extended to 2*OP_W, with no overflow possible: ZERO->0, PASSA->a, PASSB->b, ADD->a+b, SUB->a-b, MULT->full signed product.
REQ-023 DIV SHALL truncate toward zero; MOD SHALL take the sign of the dividend, with a == (a/b)*b + a%b.
REQ-024 DIV or MOD with b=0 SHALL store result 0 and err=1; every other case SHALL store err=0.
REQ-025 DIV of -2^(OP_W-1) by -1 SHALL store +2^(OP_W-1) with err=0.
REQ-026 Read: rd_en=1 at edge N SHALL present entry[read_pointer] on the rd_* outputs after edge N and raise rd_valid for exactly that cycle; 1-cycle latency.
REQ-027 With rd_en=0, rd_valid SHALL be 0 and rd_opcode..rd_entry_valid SHALL hold their last values.
REQ-028 Read and write to the same index in one cycle SHALL return the pre-write contents (read-before-write).
REQ-029 Back-to-back reads SHALL be supported every cycle.
REQ-030 entry_count SHALL increment by 1 on a write to an invalid entry and be unchanged on an overwrite; it never exceeds DEPTH.
REQ-031 Pointers SHALL index modulo DEPTH; no out-of-range condition exists.

Reset
REQ-032 reset=1 SHALL, asynchronously, clear every entry to {ZERO,0,0,0,err=0}, clear all valid bits, and drive entry_count=0, rd_valid=0 and all rd_* outputs to 0.
REQ-033 A write or read coincident with reset assertion SHALL be discarded.
REQ-034 Normal operation SHALL resume on the first rising clk after reset deasserts.

Verification (OP_W=32, DEPTH=32)
REQ-035 Reset then read entry 5 -> rd_valid=1 next cycle; rd_opcode=ZERO, rd_result=0, rd_entry_valid=0; entry_count=0.
REQ-036 Write MULT a=-7 b=6 @3, then read 3 -> rd_result=-42 (64-bit), rd_err=0, rd_entry_valid=1, entry_count=1.
REQ-037 Write DIV a=-7 b=2 @0 and MOD a=-7 b=2 @1 -> reads give -3 and -1; then DIV a=9 b=0 @2 -> result 0, rd_err=1.
REQ-038 Write ADD 1+2 @4, then in one cycle write SUB 10-3 @4 and read 4 -> that read returns 3; the following read returns 7; entry_count unchanged by the overwrite.
REQ-039 Write all 32 entries, then overwrite entry 0 -> entry_count=32 and stays 32.
REQ-040 Assert reset mid-stream with load_en=1 -> entry_count=0 immediately, rd_valid=0, and the target entry reads back invalid after reset.

Source files
------------

// File: rtl/instr_register_gen2.sv
// ----------------------------------------------------------------------------
// instr_register_gen2
//
// Register file of DEPTH instruction entries. Each write captures an opcode,
// two signed operands, the signed 2*OP_W result of applying the opcode to
// them, and a divide-by-zero flag. Reads are registered (1-cycle latency)
// and read-before-write when the same entry is read and written together.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   load_en        write strobe
//   opcode         ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
//   operand_a/b    signed operands
//   write_pointer  entry to write
//   rd_en          read request
//   read_pointer   entry to read
//   rd_valid       one-cycle pulse marking fresh read data
//   rd_opcode..rd_entry_valid  stored contents of the entry that was read
//   entry_count    number of entries written since reset
// ----------------------------------------------------------------------------
module instr_register_gen2 #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [2:0]               opcode,
    input  logic signed [OP_W-1:0]   operand_a,
    input  logic signed [OP_W-1:0]   operand_b,
    input  logic [AW-1:0]            write_pointer,
    input  logic                     rd_en,
    input  logic [AW-1:0]            read_pointer,
    output logic                     rd_valid,
    output logic [2:0]               rd_opcode,
    output logic signed [OP_W-1:0]   rd_op_a,
    output logic signed [OP_W-1:0]   rd_op_b,
    output logic signed [2*OP_W-1:0] rd_result,
    output logic                     rd_err,
    output logic                     rd_entry_valid,
    output logic [AW:0]              entry_count
);

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    // Returns {err, result}. Operands are widened to 2*OP_W first so no
    // opcode can overflow, including the -2^(OP_W-1) / -1 quotient.
    function automatic logic [2*OP_W:0] calc_result(
        input logic [2:0]             op,
        input logic signed [OP_W-1:0] a,
        input logic signed [OP_W-1:0] b
    );
        logic signed [2*OP_W-1:0] ax;
        logic signed [2*OP_W-1:0] bx;
        logic signed [2*OP_W-1:0] r;
        logic                     e;
        ax = {{OP_W{a[OP_W-1]}}, a};
        bx = {{OP_W{b[OP_W-1]}}, b};
        r  = '0;
        e  = 1'b0;
        case (opcode_t'(op))
            ZERO:  r = '0;
            PASSA: r = ax;
            PASSB: r = bx;
            ADD:   r = ax + bx;
            SUB:   r = ax - bx;
            MULT:  r = ax * bx;
            // Signed / and % truncate toward zero, remainder follows dividend.
            DIV: begin
                if (bx == '0) e = 1'b1;
                else          r = ax / bx;
            end
            MOD: begin
                if (bx == '0) e = 1'b1;
                else          r = ax % bx;
            end
            default: r = '0;
        endcase
        return {e, r};
    endfunction

    logic [2:0]               mem_op  [DEPTH];
    logic signed [OP_W-1:0]   mem_a   [DEPTH];
    logic signed [OP_W-1:0]   mem_b   [DEPTH];
    logic signed [2*OP_W-1:0] mem_res [DEPTH];
    logic [DEPTH-1:0]         mem_err;
    logic [DEPTH-1:0]         mem_vld;

    // ---- stage p0: result computed combinationally from the write inputs ----
    logic [2*OP_W:0]          wr_calc_p0;
    logic signed [2*OP_W-1:0] wr_res_p0;
    logic                     wr_err_p0;

    always_comb begin
        wr_calc_p0 = calc_result(opcode, operand_a, operand_b);
        wr_err_p0  = wr_calc_p0[2*OP_W];
        wr_res_p0  = wr_calc_p0[2*OP_W-1:0];
    end

    // ---- stage p1: storage update and registered read port ----
    // The read samples the array before this edge's write lands, which gives
    // read-before-write on a shared index without any bypass logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_op[i]  <= 3'd0;
                mem_a[i]   <= '0;
                mem_b[i]   <= '0;
                mem_res[i] <= '0;
            end
            mem_err        <= '0;
            mem_vld        <= '0;
            entry_count    <= '0;
            rd_valid       <= 1'b0;
            rd_opcode      <= 3'd0;
            rd_op_a        <= '0;
            rd_op_b        <= '0;
            rd_result      <= '0;
            rd_err         <= 1'b0;
            rd_entry_valid <= 1'b0;
        end else begin
            if (load_en) begin
                mem_op[write_pointer]  <= opcode;
                mem_a[write_pointer]   <= operand_a;
                mem_b[write_pointer]   <= operand_b;
                mem_res[write_pointer] <= wr_res_p0;
                mem_err[write_pointer] <= wr_err_p0;
                mem_vld[write_pointer] <= 1'b1;
                // Only first writes to an entry grow the count, so it is
                // bounded by DEPTH by construction.
                if (!mem_vld[write_pointer])
                    entry_count <= entry_count + (AW+1)'(1);
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_opcode      <= mem_op[read_pointer];
                rd_op_a        <= mem_a[read_pointer];
                rd_op_b        <= mem_b[read_pointer];
                rd_result      <= mem_res[read_pointer];
                rd_err         <= mem_err[read_pointer];
                rd_entry_valid <= mem_vld[read_pointer];
            end
        end
    end

endmodule

// File: tb/tb_instr_register_gen2.sv
module tb_instr_register_gen2;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, MULT = 3'd5, DIV = 3'd6, MOD = 3'd7;

    logic                  clk;
    logic                  reset;
    logic                  load_en;
    logic [2:0]            opcode;
    logic signed [W-1:0]   operand_a;
    logic signed [W-1:0]   operand_b;
    logic [AW-1:0]         write_pointer;
    logic                  rd_en;
    logic [AW-1:0]         read_pointer;
    logic                  rd_valid;
    logic [2:0]            rd_opcode;
    logic signed [W-1:0]   rd_op_a;
    logic signed [W-1:0]   rd_op_b;
    logic signed [2*W-1:0] rd_result;
    logic                  rd_err;
    logic                  rd_entry_valid;
    logic [AW:0]           entry_count;

    instr_register_gen2 #(.OP_W(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .rd_en(rd_en),
        .read_pointer(read_pointer), .rd_valid(rd_valid),
        .rd_opcode(rd_opcode), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
        .rd_result(rd_result), .rd_err(rd_err),
        .rd_entry_valid(rd_entry_valid), .entry_count(entry_count)
    );

    typedef struct packed {
        logic [2:0]            op;
        logic signed [W-1:0]   a;
        logic signed [W-1:0]   b;
        logic signed [2*W-1:0] res;
        logic                  err;
        logic                  ev;
    } rec_t;

    rec_t mem [D];
    rec_t exp_q [$];
    rec_t last;
    logic exp_vld;
    int   exp_cnt;
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Monitor: checks every mid-cycle; pops the scoreboard when rd_valid is up.
    always @(negedge clk) begin
        rec_t got;
        rec_t e;
        got = '{op: rd_opcode, a: rd_op_a, b: rd_op_b, res: rd_result,
                err: rd_err, ev: rd_entry_valid};
        total++;
        if (rd_valid !== exp_vld) begin
            bad++;
            $display("FAIL rd_valid: got=%b exp=%b t=%0t", rd_valid, exp_vld, $time);
        end
        total++;
        if (entry_count !== (AW+1)'(exp_cnt)) begin
            bad++;
            $display("FAIL entry_count: got=%0d exp=%0d t=%0t", entry_count, exp_cnt, $time);
        end
        if (rd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: rd_valid with empty scoreboard t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL read_data: got op=%0d a=%0d b=%0d res=%0d err=%b ev=%b exp op=%0d a=%0d b=%0d res=%0d err=%b ev=%b t=%0t",
                             got.op, got.a, got.b, got.res, got.err, got.ev,
                             e.op, e.a, e.b, e.res, e.err, e.ev, $time);
                end
                last = e;
            end
        end else begin
            total++;
            if (got !== last) begin
                bad++;
                $display("FAIL hold: got op=%0d a=%0d b=%0d res=%0d err=%b ev=%b exp op=%0d a=%0d b=%0d res=%0d err=%b ev=%b t=%0t",
                         got.op, got.a, got.b, got.res, got.err, got.ev,
                         last.op, last.a, last.b, last.res, last.err, last.ev, $time);
            end
        end
    end

    // One clock of stimulus, driven just after a rising edge. After the next
    // edge the model is advanced: read sees pre-write contents.
    task automatic cycle(input bit we, input logic [2:0] op,
                         input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input logic signed [2*W-1:0] er, input bit ee, input int wp,
                         input bit re, input int rp);
        rec_t r;
        load_en       = we;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        write_pointer = AW'(wp);
        rd_en         = re;
        read_pointer  = AW'(rp);
        @(posedge clk);
        if (re) exp_q.push_back(mem[rp % D]);
        exp_vld = re;
        if (we) begin
            if (!mem[wp % D].ev) exp_cnt++;
            r = '{op: op, a: a, b: b, res: er, err: ee, ev: 1'b1};
            mem[wp % D] = r;
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] op, input logic signed [W-1:0] a,
                      input logic signed [W-1:0] b, input logic signed [2*W-1:0] er,
                      input bit ee, input int wp);
        cycle(1'b1, op, a, b, er, ee, wp, 1'b0, 0);
    endtask

    task automatic rd(input int rp);
        cycle(1'b0, ZERO, '0, '0, '0, 1'b0, 0, 1'b1, rp);
    endtask

    task automatic idle();
        cycle(1'b0, ZERO, '0, '0, '0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) mem[i] = '0;
        exp_q.delete();
        last    = '0;
        exp_vld = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        reset = 1'b1;
        load_en = 1'b0; opcode = ZERO; operand_a = '0; operand_b = '0;
        write_pointer = '0; rd_en = 1'b0; read_pointer = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        rd(5);
        // multiply
        wr(MULT, -32'sd7, 32'sd6, -64'sd42, 1'b0, 3);
        rd(3);
        // divide / modulo, back-to-back reads
        wr(DIV, -32'sd7, 32'sd2, -64'sd3, 1'b0, 0);
        wr(MOD, -32'sd7, 32'sd2, -64'sd1, 1'b0, 1);
        rd(0);
        rd(1);
        wr(DIV, 32'sd9, 32'sd0, 64'sd0, 1'b1, 2);
        rd(2);
        wr(DIV, 32'sh80000000, -32'sd1, 64'sd2147483648, 1'b0, 6);
        wr(MOD, 32'sd5, 32'sd0, 64'sd0, 1'b1, 7);
        wr(MOD, 32'sd7, -32'sd2, 64'sd1, 1'b0, 8);
        rd(6);
        rd(7);
        rd(8);
        // read-before-write on the same index
        wr(ADD, 32'sd1, 32'sd2, 64'sd3, 1'b0, 4);
        cycle(1'b1, SUB, 32'sd10, 32'sd3, 64'sd7, 1'b0, 4, 1'b1, 4);
        rd(4);
        // wide results, pass-through, zero
        wr(ADD, 32'sh7fffffff, 32'sh7fffffff, 64'sh00000000fffffffe, 1'b0, 11);
        wr(SUB, 32'sh80000000, 32'sd1, -64'sd2147483649, 1'b0, 12);
        wr(ZERO, 32'sd5, 32'sd6, 64'sd0, 1'b0, 13);
        wr(PASSB, 32'sd5, -32'sd9, -64'sd9, 1'b0, 10);
        rd(11);
        rd(12);
        rd(13);
        rd(10);
        idle();
        // fill all entries, then overwrite entry 0
        for (int i = 0; i < D; i++)
            wr(PASSA, W'(i), 32'sd0, 64'(i), 1'b0, i);
        rd(31);
        wr(SUB, 32'sd0, 32'sd1, -64'sd1, 1'b0, 0);
        rd(0);
        rd(20);
        // asynchronous reset mid-stream with a write and read pending
        load_en = 1'b1; opcode = ADD; operand_a = 32'sd4; operand_b = 32'sd4;
        write_pointer = AW'(9); rd_en = 1'b1; read_pointer = AW'(9);
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (entry_count !== '0 || rd_valid !== 1'b0 || rd_result !== '0) begin
            bad++;
            $display("FAIL async_reset: got cnt=%0d vld=%b res=%0d exp cnt=0 vld=0 res=0",
                     entry_count, rd_valid, rd_result);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(9);
        wr(ADD, 32'sd2, 32'sd3, 64'sd5, 1'b0, 9);
        rd(9);
        idle();
        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d exp pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
